instr_sequencer: RTL and testbench



---
 rtl/instr_sequencer.sv | 165 ++++++++++++++++
 tb/tb_instr_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// instr_sequencer: program sequencer for the register-file control unit.
// Holds a writable instruction memory and fetches it in order. Each
// instruction is issued with a one-cycle go strobe and its decoded register
// fields. The sequencer then waits for done and advances to the next word.
// Execution stops on a HALT opcode (4'hF), at the last memory word, or when
// done does not arrive in time.
//
// Ports:
//   clock, reset       rising-edge clock; synchronous active-high reset
//   start              begin execution at pc 0 (honoured in IDLE / HALT)
//   prog_we/addr/data  instruction-memory write port (ignored while busy)
//   done               control unit finished the issued instruction
//   go                 one-cycle issue strobe
//   opcode/dst/src1/src2  decoded fields of the current instruction
//   pc                 address of the current instruction
//   busy/halted/error  state flags (FETCH|ISSUE|WAIT, HALT, ERROR)
//   retired            completed-instruction count, wraps
module instr_sequencer #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned PROG_DEPTH = 16,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          prog_we,
  input  logic [$clog2(PROG_DEPTH)-1:0] prog_addr,
  input  logic [WIDTH-1:0]              prog_data,
  input  logic                          done,
  output logic                          go,
  output logic [3:0]                    opcode,
  output logic [$clog2(DEPTH)-1:0]      dst,
  output logic [$clog2(DEPTH)-1:0]      src1,
  output logic [$clog2(DEPTH)-1:0]      src2,
  output logic [$clog2(PROG_DEPTH)-1:0] pc,
  output logic                          busy,
  output logic                          halted,
  output logic                          error,
  output logic [WIDTH-1:0]              retired
);

  localparam int unsigned RW  = $clog2(DEPTH);
  localparam int unsigned PW  = $clog2(PROG_DEPTH);
  localparam int unsigned TW  = ($clog2(TIMEOUT) > 0) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned LOW = WIDTH - 4 - 3 * RW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_HALT,
    S_ERROR
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [PROG_DEPTH];
  logic [WIDTH-1:0] ir;
  logic [WIDTH-1:0] fetch_word;
  logic [TW-1:0]    wait_cnt;
  logic             prog_ok;

  // Memory is writable only while nothing is executing.
  assign prog_ok    = (state == S_IDLE) || (state == S_HALT) || (state == S_ERROR);
  assign fetch_word = mem[pc];

  // Instruction memory; deliberately not reset.
  always_ff @(posedge clock) begin
    if (prog_we && prog_ok) begin
      mem[prog_addr] <= prog_data;
    end
  end

  // Field decode straight from the instruction register.
  assign opcode = ir[WIDTH-1 -: 4];
  assign dst    = ir[WIDTH-5 -: RW];
  assign src1   = ir[WIDTH-5-RW -: RW];
  assign src2   = ir[WIDTH-5-2*RW -: RW];

  if (LOW > 0) begin : g_low_bits
    logic unused_low;
    assign unused_low = ^ir[LOW-1:0];
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      go       <= 1'b0;
      ir       <= '0;
      pc       <= '0;
      busy     <= 1'b0;
      halted   <= 1'b0;
      error    <= 1'b0;
      retired  <= '0;
      wait_cnt <= '0;
    end else begin
      go <= 1'b0;
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            state   <= S_FETCH;
            pc      <= '0;
            retired <= '0;
            busy    <= 1'b1;
            halted  <= 1'b0;
          end
        end

        // Latch the word; a HALT opcode stops here so no go is ever issued for it.
        S_FETCH: begin
          ir <= fetch_word;
          if (fetch_word[WIDTH-1 -: 4] == 4'hF) begin
            state  <= S_HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else begin
            state <= S_ISSUE;
            go    <= 1'b1;
          end
        end

        // done during the go cycle is not an acknowledge.
        S_ISSUE: begin
          state    <= S_WAIT;
          wait_cnt <= '0;
        end

        // done takes priority over an expiring timeout in the same cycle.
        S_WAIT: begin
          if (done) begin
            retired <= retired + WIDTH'(1);
            if (pc == PW'(PROG_DEPTH - 1)) begin
              state  <= S_HALT;
              busy   <= 1'b0;
              halted <= 1'b1;
            end else begin
              pc    <= pc + PW'(1);
              state <= S_FETCH;
            end
          end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
            state <= S_ERROR;
            busy  <= 1'b0;
            error <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end

        S_ERROR: begin
          state <= S_ERROR;
        end

        default: begin
          state  <= S_IDLE;
          busy   <= 1'b0;
          halted <= 1'b0;
          error  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer.
module tb_instr_sequencer;

  logic        clock;
  logic        reset;
  logic        start;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [15:0] prog_data;
  logic        done;
  logic        go;
  logic [3:0]  opcode;
  logic [2:0]  dst;
  logic [2:0]  src1;
  logic [2:0]  src2;
  logic [3:0]  pc;
  logic        busy;
  logic        halted;
  logic        error;
  logic [15:0] retired;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;
  int unsigned go_seen  = 0;

  instr_sequencer dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .done      (done),
    .go        (go),
    .opcode    (opcode),
    .dst       (dst),
    .src1      (src1),
    .src2      (src2),
    .pc        (pc),
    .busy      (busy),
    .halted    (halted),
    .error     (error),
    .retired   (retired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) if (go === 1'b1) go_seen <= go_seen + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no end of test, expected $finish before 100000 ns");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_word(input logic [3:0] addr, input logic [15:0] data);
    prog_we   = 1'b1;
    prog_addr = addr;
    prog_data = data;
    tick();
    prog_we   = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, " go"},      32'(go),      32'h0);
    check({tag, " opcode"},  32'(opcode),  32'h0);
    check({tag, " dst"},     32'(dst),     32'h0);
    check({tag, " src1"},    32'(src1),    32'h0);
    check({tag, " src2"},    32'(src2),    32'h0);
    check({tag, " pc"},      32'(pc),      32'h0);
    check({tag, " busy"},    32'(busy),    32'h0);
    check({tag, " halted"},  32'(halted),  32'h0);
    check({tag, " error"},   32'(error),   32'h0);
    check({tag, " retired"}, 32'(retired), 32'h0);
  endtask

  // Runs the 16-word program, acking each instruction on its 4th WAIT cycle.
  // During instruction 2 a write of HALT to word 3 is attempted; it must be dropped.
  task automatic run_program(input string tag);
    int unsigned g0;
    int unsigned t_ref;
    g0    = go_seen;
    t_ref = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      for (int n = 0; n < 20 && go !== 1'b1; n++) tick();
      check($sformatf("%s go present %0d", tag, k), 32'(go), 32'h1);
      check($sformatf("%s go spacing %0d", tag, k), cyc - t_ref, (k == 0) ? 32'd2 : 32'd6);
      check($sformatf("%s dst %0d", tag, k), 32'(dst), 32'(k % 8));
      check($sformatf("%s src2 %0d", tag, k), 32'(src2), 32'((k + 2) % 8));
      t_ref = cyc;
      tick();
      if (k == 2) begin
        prog_we   = 1'b1;
        prog_addr = 4'd3;
        prog_data = 16'hF000;
      end
      tick();
      prog_we = 1'b0;
      tick();
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
    end
    check({tag, " halted"},  32'(halted),  32'h1);
    check({tag, " busy"},    32'(busy),    32'h0);
    check({tag, " pc"},      32'(pc),      32'hF);
    check({tag, " retired"}, 32'(retired), 32'h10);
    check({tag, " go count"}, go_seen - g0, 32'd16);
  endtask

  initial begin
    int unsigned g0;
    int unsigned t0;
    reset     = 1'b1;
    start     = 1'b0;
    prog_we   = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    done      = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check_reset("reset");

    // Two-word program: one instruction then HALT; done held high throughout.
    write_word(4'd0, 16'h1248);
    write_word(4'd1, 16'hF000);
    g0    = go_seen;
    t0    = cyc;
    start = 1'b1;
    done  = 1'b1;
    tick();
    start = 1'b0;
    check("t1 fetch busy", 32'(busy), 32'h1);
    check("t1 fetch go",   32'(go),   32'h0);
    tick();
    check("t1 go",      32'(go),     32'h1);
    check("t1 go time", cyc - t0,    32'd2);
    check("t1 opcode",  32'(opcode), 32'h1);
    check("t1 dst",     32'(dst),    32'h1);
    check("t1 src1",    32'(src1),   32'h1);
    check("t1 src2",    32'(src2),   32'h1);
    tick();
    check("t1 wait go", 32'(go), 32'h0);
    tick();
    check("t1 retired", 32'(retired), 32'h1);
    check("t1 pc",      32'(pc),      32'h1);
    tick();
    done = 1'b0;
    check("t1 halted",   32'(halted),  32'h1);
    check("t1 busy",     32'(busy),    32'h0);
    check("t1 pc halt",  32'(pc),      32'h1);
    check("t1 ret halt", 32'(retired), 32'h1);
    check("t1 go count", go_seen - g0, 32'd1);

    // Fill memory with opcode 2 and distinct fields, then run it.
    for (int k = 0; k < 16; k++) begin
      write_word(4'(k), {4'h2, 3'(k), 3'(k + 1), 3'(k + 2), 3'b000});
    end
    run_program("fill");

    // done in the ISSUE cycle only must not advance.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("t4 go", 32'(go), 32'h1);
    done = 1'b1;
    tick();
    done = 1'b0;
    check("t4 busy",    32'(busy),    32'h1);
    check("t4 retired", 32'(retired), 32'h0);
    check("t4 pc",      32'(pc),      32'h0);
    tick();
    tick();
    check("t4 still waiting", 32'(retired), 32'h0);
    check("t4 no go",         32'(go),      32'h0);
    done = 1'b1;
    tick();
    done = 1'b0;
    check("t4 advance retired", 32'(retired), 32'h1);
    check("t4 advance pc",      32'(pc),      32'h1);

    // Reset in WAIT, then a re-run must reproduce the same go sequence.
    tick();
    check("t5 go pc1",  32'(go),  32'h1);
    check("t5 dst pc1", 32'(dst), 32'h1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset("midreset");
    run_program("rerun");

    // done on the very last WAIT cycle wins; the next instruction times out.
    g0    = go_seen;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 63; i++) tick();
    check("t3 last chance error", 32'(error), 32'h0);
    check("t3 last chance busy",  32'(busy),  32'h1);
    done = 1'b1;
    tick();
    done = 1'b0;
    check("t3 done wins error",   32'(error),   32'h0);
    check("t3 done wins retired", 32'(retired), 32'h1);
    tick();
    tick();
    for (int i = 0; i < 63; i++) tick();
    check("t3 pre-timeout error", 32'(error), 32'h0);
    tick();
    check("t3 error",   32'(error),   32'h1);
    check("t3 busy",    32'(busy),    32'h0);
    check("t3 halted",  32'(halted),  32'h0);
    check("t3 pc",      32'(pc),      32'h1);
    check("t3 retired", 32'(retired), 32'h1);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("t3 sticky error", 32'(error), 32'h1);
    check("t3 start ignored busy", 32'(busy), 32'h0);
    check("t3 go count", go_seen - g0, 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset("errreset");

    // Write and start in the same IDLE cycle: fetch at pc 0 sees the new HALT word.
    g0        = go_seen;
    prog_we   = 1'b1;
    prog_addr = 4'd0;
    prog_data = 16'hF000;
    start     = 1'b1;
    tick();
    prog_we = 1'b0;
    start   = 1'b0;
    check("t7 fetch busy", 32'(busy), 32'h1);
    tick();
    check("t7 halted",   32'(halted),  32'h1);
    check("t7 busy",     32'(busy),    32'h0);
    check("t7 pc",       32'(pc),      32'h0);
    check("t7 retired",  32'(retired), 32'h0);
    tick();
    check("t7 no go", go_seen - g0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
